hazard_control_unit: RTL

- Second-generation hazard unit for the 5-stage pipelined RISC-V core; replaces the single-cycle load-use detector.
- Adds a parametrised multi-cycle load-use stall FSM, x0 and operand-use qualification, taken-branch flush, EX-stage forwarding selects, and saturating stall/flush performance counters.
- Sits between the ID/EX/MEM/WB pipeline registers and drives the PC enable, IF/ID enable/flush, the ID/EX NOP mux and the ALU operand forwarding muxes.

---
 rtl/hazard_control_unit_if.sv | 45 ++++
 rtl/hazard_control_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side bundle between the pipeline registers and the hazard unit
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_register_rd;
    logic                  ex_branch_taken;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_register_rd;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_register_rd;

    logic                  PCWrite;
    logic                  if_id_enable;
    logic                  enable_nop_mux;
    logic                  if_id_flush;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  stall_busy;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rs1, ex_rs2, ex_mem_read, ex_register_rd, ex_branch_taken,
        input  mem_reg_write, mem_register_rd, wb_reg_write, wb_register_rd,
        output PCWrite, if_id_enable, enable_nop_mux, if_id_flush,
        output forward_a, forward_b, stall_busy, stall_count, flush_count
    );

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rs1, ex_rs2, ex_mem_read, ex_register_rd, ex_branch_taken,
        output mem_reg_write, mem_register_rd, wb_reg_write, wb_register_rd,
        input  PCWrite, if_id_enable, enable_nop_mux, if_id_flush,
        input  forward_a, forward_b, stall_busy, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall FSM, branch flush, EX forwarding and stall/flush counters
module hazard_control_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    hazard_control_unit_if.slave bus
);
    localparam int REM_W = $clog2(LOAD_STALL_CYCLES) + 1;
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {IDLE, STALL} state_t;

    state_t           state, state_nx;
    logic [REM_W-1:0] rem, rem_nx;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             stall_inc, flush_inc;
    logic             rs1_hit, rs2_hit, haz;
    logic             pc_write, ifid_en, nop_sel, ifid_flush, busy;

    // x0 as a load destination never stalls; unused source fields are don't-care
    assign rs1_hit = bus.id_uses_rs1 && (bus.ex_register_rd == bus.id_rs1);
    assign rs2_hit = bus.id_uses_rs2 && (bus.ex_register_rd == bus.id_rs2);
    assign haz     = bus.ex_mem_read && (bus.ex_register_rd != '0) && (rs1_hit || rs2_hit);

    function automatic logic [1:0] fwd_sel(
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            rem       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        rem_nx     = rem;
        pc_write   = 1'b1;
        ifid_en    = 1'b1;
        nop_sel    = 1'b0;
        ifid_flush = 1'b0;
        busy       = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    nop_sel    = 1'b1;
                    flush_inc  = 1'b1;
                end else if (haz) begin
                    pc_write  = 1'b0;
                    ifid_en   = 1'b0;
                    nop_sel   = 1'b1;
                    stall_inc = 1'b1;
                    rem_nx    = REM_LOAD;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nx = STALL;
                    end
                end
            end
            STALL: begin
                // EX holds a bubble here, so haz and branch inputs are meaningless
                pc_write  = 1'b0;
                ifid_en   = 1'b0;
                nop_sel   = 1'b1;
                busy      = 1'b1;
                stall_inc = 1'b1;
                rem_nx    = rem - REM_W'(1);
                if (rem <= REM_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                rem_nx   = '0;
            end
        endcase
    end

    // Reset forces a safe frozen pipeline: nothing advances, ID/EX is bubbled
    always_comb begin
        bus.PCWrite        = pc_write;
        bus.if_id_enable   = ifid_en;
        bus.enable_nop_mux = nop_sel;
        bus.if_id_flush    = ifid_flush;
        bus.stall_busy     = busy;
        bus.forward_a      = fwd_sel(bus.mem_reg_write, bus.mem_register_rd,
                                     bus.wb_reg_write, bus.wb_register_rd, bus.ex_rs1);
        bus.forward_b      = fwd_sel(bus.mem_reg_write, bus.mem_register_rd,
                                     bus.wb_reg_write, bus.wb_register_rd, bus.ex_rs2);
        if (RESET) begin
            bus.PCWrite        = 1'b0;
            bus.if_id_enable   = 1'b0;
            bus.enable_nop_mux = 1'b1;
            bus.if_id_flush    = 1'b0;
            bus.stall_busy     = 1'b0;
            bus.forward_a      = 2'b00;
            bus.forward_b      = 2'b00;
        end
    end

    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;
endmodule
